counter_updown_param: RTL and testbench

//  Parametrised up/down counter: successor to the fixed 8-bit load/clear counter.

---
 rtl/counter_updown_param.sv | 130 +++++++++++++
 tb/tb_counter_updown_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_param.sv
// ----------------------------------------------------------------------------
// counter_updown_param
//   Parametrised up/down event/timebase counter with programmable terminal
//   value (limit), wrap or saturate behaviour, count enable, registered
//   terminal-count pulse and sticky overflow flag.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   STEP      increment/decrement magnitude per enabled cycle
//   SATURATE  0 = wrap within 0..limit, 1 = saturate at 0 / limit
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   en      in   count enable, one step per cycle while high
//   mode    in   1 = count up, 0 = count down
//   ld      in   synchronous load of min(d_in, limit)   (highest priority)
//   clr     in   synchronous clear of count and ovf
//   d_in    in   load value
//   limit   in   terminal value, legal count range 0..limit
//   count   out  registered counter value
//   tc      out  registered one-cycle pulse on a wrap/saturation event
//   ovf     out  sticky overflow, set with tc, cleared by clr or reset
//   zero    out  combinational count == 0
//   at_max  out  combinational count == limit
// ----------------------------------------------------------------------------
module counter_updown_param #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             zero,
    output logic             at_max
);

    localparam logic [WIDTH:0] LP_STEP = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    // All boundary arithmetic is one bit wider than the counter so that
    // count+STEP and limit+1 never lose their carry.
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_lim_x;
    logic [WIDTH:0]   w_lim_p1;
    logic [WIDTH:0]   w_up;
    logic             w_illegal;
    logic             w_up_bnd;
    logic             w_dn_bnd;
    logic [WIDTH-1:0] w_ld_val;
    logic [WIDTH-1:0] w_nxt_cnt;
    logic             w_bnd;

    assign w_cnt_x   = {1'b0, r_count};
    assign w_lim_x   = {1'b0, limit};
    assign w_lim_p1  = w_lim_x + 1'b1;
    assign w_up      = w_cnt_x + LP_STEP;
    assign w_illegal = (w_lim_p1 < LP_STEP);
    // A count above a lowered limit also trips the up boundary here.
    assign w_up_bnd  = (w_up > w_lim_x);
    assign w_dn_bnd  = (w_cnt_x < LP_STEP);
    assign w_ld_val  = (d_in > limit) ? limit : d_in;

    // Next count for an enabled step. With a legal limit (STEP <= limit+1)
    // both wrap results fit in WIDTH bits, so the casts drop only zeros.
    always_comb begin
        w_nxt_cnt = r_count;
        w_bnd     = 1'b0;
        if (!w_illegal) begin
            if (mode) begin
                if (w_up_bnd) begin
                    w_bnd     = 1'b1;
                    w_nxt_cnt = (SATURATE != 0) ? limit : WIDTH'(w_up - w_lim_p1);
                end else begin
                    w_nxt_cnt = WIDTH'(w_up);
                end
            end else begin
                if (w_dn_bnd) begin
                    w_bnd     = 1'b1;
                    w_nxt_cnt = (SATURATE != 0) ? '0
                                                : WIDTH'(w_cnt_x + w_lim_p1 - LP_STEP);
                end else begin
                    w_nxt_cnt = WIDTH'(w_cnt_x - LP_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (ld) begin
            r_count <= w_ld_val;
            r_tc    <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (en) begin
            r_count <= w_nxt_cnt;
            r_tc    <= w_bnd;
            if (w_bnd) begin
                r_ovf <= 1'b1;
            end
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count  = r_count;
    assign tc     = r_tc;
    assign ovf    = r_ovf;
    assign zero   = (r_count == '0);
    assign at_max = (r_count == limit);

endmodule

// File: tb/tb_counter_updown_param.sv
// ----------------------------------------------------------------------------
// tb_counter_updown_param
//   Drives three counter variants from shared controls:
//     inst 0: WIDTH=8 STEP=1 wrap
//     inst 1: WIDTH=8 STEP=1 saturate
//     inst 2: WIDTH=8 STEP=3 wrap
//   and compares every output against an integer reference model each cycle.
// ----------------------------------------------------------------------------
module tb_counter_updown_param;

    localparam int NI = 3;
    localparam int P_STEP [NI] = '{1, 1, 3};
    localparam int P_SAT  [NI] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, ld, clr;
    logic [7:0] d_in, limit;

    logic [7:0] q_cnt  [NI];
    logic       q_tc   [NI];
    logic       q_ovf  [NI];
    logic       q_zero [NI];
    logic       q_max  [NI];

    int m_cnt [NI];
    int m_tc  [NI];
    int m_ovf [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    counter_updown_param #(.WIDTH(8), .STEP(1), .SATURATE(0)) u_wrap1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .clr(clr),
        .d_in(d_in), .limit(limit), .count(q_cnt[0]), .tc(q_tc[0]),
        .ovf(q_ovf[0]), .zero(q_zero[0]), .at_max(q_max[0]));

    counter_updown_param #(.WIDTH(8), .STEP(1), .SATURATE(1)) u_sat1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .clr(clr),
        .d_in(d_in), .limit(limit), .count(q_cnt[1]), .tc(q_tc[1]),
        .ovf(q_ovf[1]), .zero(q_zero[1]), .at_max(q_max[1]));

    counter_updown_param #(.WIDTH(8), .STEP(3), .SATURATE(0)) u_wrap3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .clr(clr),
        .d_in(d_in), .limit(limit), .count(q_cnt[2]), .tc(q_tc[2]),
        .ovf(q_ovf[2]), .zero(q_zero[2]), .at_max(q_max[2]));

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
            m_ovf[i] = 0;
        end
    endfunction

    // Behaviour on one rising edge, from the counting rules in plain integers.
    function automatic void model_edge();
        int lim, st, nxt;
        lim = int'(limit);
        for (int i = 0; i < NI; i++) begin
            st = P_STEP[i];
            if (!rst_n) begin
                m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end else if (ld) begin
                m_cnt[i] = (int'(d_in) < lim) ? int'(d_in) : lim;
                m_tc[i]  = 0;
            end else if (clr) begin
                m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end else if (!en) begin
                m_tc[i] = 0;
            end else if (lim + 1 < st) begin
                m_tc[i] = 0;
            end else if (mode) begin
                nxt = m_cnt[i] + st;
                if (nxt > lim) begin
                    m_cnt[i] = P_SAT[i] ? lim : nxt - (lim + 1);
                    m_tc[i] = 1; m_ovf[i] = 1;
                end else begin
                    m_cnt[i] = nxt; m_tc[i] = 0;
                end
            end else begin
                if (m_cnt[i] < st) begin
                    m_cnt[i] = P_SAT[i] ? 0 : m_cnt[i] + (lim + 1) - st;
                    m_tc[i] = 1; m_ovf[i] = 1;
                end else begin
                    m_cnt[i] = m_cnt[i] - st; m_tc[i] = 0;
                end
            end
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("count[%0d]", i),  int'(q_cnt[i]),  m_cnt[i]);
            check_val($sformatf("tc[%0d]", i),     int'(q_tc[i]),   m_tc[i]);
            check_val($sformatf("ovf[%0d]", i),    int'(q_ovf[i]),  m_ovf[i]);
            check_val($sformatf("zero[%0d]", i),   int'(q_zero[i]), int'(m_cnt[i] == 0));
            check_val($sformatf("at_max[%0d]", i), int'(q_max[i]),  int'(m_cnt[i] == int'(limit)));
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_ctl(input logic i_ld, input logic i_clr, input logic i_en,
                           input logic i_mode);
        ld = i_ld; clr = i_clr; en = i_en; mode = i_mode;
    endtask

    initial begin
        rst_n = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        d_in  = 8'd0;
        limit = 8'd255;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Async reset mid-cycle with a non-zero count, held across an edge.
        d_in = 8'h37;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        step_cycle();
        check_val("load_37", int'(q_cnt[0]), 8'h37);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_val("async_rst_cnt", int'(q_cnt[0]), 0);
        check_val("async_rst_tc",  int'(q_tc[0]),  0);
        check_val("async_rst_ovf", int'(q_ovf[0]), 0);
        step_cycle();
        check_val("rst_hold_cnt", int'(q_cnt[0]), 0);
        rst_n = 1'b1;

        // Wrap at limit 9 counting up.
        limit = 8'd9;
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1);
        step_cycle();
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) step_cycle();
        check_val("up9_cnt", int'(q_cnt[0]), 9);
        check_val("up9_tc",  int'(q_tc[0]),  0);
        step_cycle();
        check_val("wrap_cnt", int'(q_cnt[0]), 0);
        check_val("wrap_tc",  int'(q_tc[0]),  1);
        step_cycle();
        check_val("after_wrap_tc",  int'(q_tc[0]),  0);
        check_val("after_wrap_ovf", int'(q_ovf[0]), 1);

        // Down from 0 with full range, then clear.
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1);
        step_cycle();
        limit = 8'd255;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        step_cycle();
        check_val("dn_wrap_cnt", int'(q_cnt[0]), 255);
        check_val("dn_wrap_tc",  int'(q_tc[0]),  1);
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        step_cycle();
        check_val("clr_cnt", int'(q_cnt[0]), 0);
        check_val("clr_ovf", int'(q_ovf[0]), 0);

        // Saturating instance: load clipped to limit, then pinned at the top.
        limit = 8'd200;
        d_in  = 8'd250;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        step_cycle();
        check_val("sat_ld_cnt",    int'(q_cnt[1]), 200);
        check_val("sat_ld_at_max", int'(q_max[1]), 1);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step_cycle();
            check_val("sat_hold_cnt", int'(q_cnt[1]), 200);
            check_val("sat_hold_tc",  int'(q_tc[1]),  1);
        end

        // ld wins over clr and en; ovf is left alone by the load.
        limit = 8'd255;
        d_in  = 8'h5A;
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
        step_cycle();
        check_val("prio_cnt",  int'(q_cnt[0]), 8'h5A);
        check_val("prio_ovf0", int'(q_ovf[0]), 1);
        check_val("prio_ovf1", int'(q_ovf[1]), 1);
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1);
        step_cycle();
        check_val("clr2_cnt",  int'(q_cnt[0]),  0);
        check_val("clr2_zero", int'(q_zero[0]), 1);

        // STEP=3 wrap both directions, then an illegal limit holds.
        limit = 8'd10;
        d_in  = 8'd9;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
        step_cycle();
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        step_cycle();
        check_val("s3_up_cnt", int'(q_cnt[2]), 1);
        check_val("s3_up_tc",  int'(q_tc[2]),  1);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        step_cycle();
        check_val("s3_dn_cnt", int'(q_cnt[2]), 9);
        check_val("s3_dn_tc",  int'(q_tc[2]),  1);
        limit = 8'd1;
        step_cycle();
        check_val("s3_illegal_cnt", int'(q_cnt[2]), 9);
        check_val("s3_illegal_tc",  int'(q_tc[2]),  0);

        // Randomised traffic, including runtime limit changes and resets.
        for (int k = 0; k < 600; k++) begin
            ld   = ($urandom_range(0, 15) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 1) != 0;
            d_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4))
                                                    : 8'($urandom_range(0, 255));
            end
            if (!rst_n) begin
                if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                compare_all();
            end
            step_cycle();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
